// File: rtl/multiword_seq_adder.sv
// multiword_seq_adder: adds two WORDS x 16-bit operands and a carry-in,
// one 16-bit slice per cycle, LSB slice first. A single 16-bit
// recursive-doubling (kpg) adder is reused for every slice, and each
// slice's carry-out becomes the next slice's carry-in. Operands come in
// on a valid/ready handshake, and the result leaves on another.
//
// Optional build macro MULTIWORD_SUB_EN adds a 'sub' input. With sub=1 the
// block computes A - B modulo 2^W. In that mode cout=1 means no borrow.

// 16-bit recursive-doubling adder. Its result is {carry, sum}.
module kpg_adder16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [16:0] res
);

  logic [4:0][15:0] g;
  logic [4:0][15:0] p;
  logic [16:0]      c;

  // Prefix tree. Level l combines each bit with the group d = 2^(l-1) below it.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    g = '0;
    p = '0;
    c = '0;
    g[0] = a & b;
    p[0] = a ^ b;
    for (int l = 1; l < 5; l++) begin
      // Low bits (below d) have no partner group; ones-fill keeps their p unchanged.
      g[l] = g[l-1] | (p[l-1] & (g[l-1] << (1 << (l - 1))));
      p[l] = p[l-1] & ((p[l-1] << (1 << (l - 1))) | ~(16'hFFFF << (1 << (l - 1))));
    end
    c[0]    = cin;
    c[16:1] = g[4] | (p[4] & {16{cin}});
    res     = {c[16], p[0] ^ c[15:0]};
  end

endmodule

module multiword_seq_adder #(
  parameter int WORDS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [16*WORDS-1:0] a,
  input  logic [16*WORDS-1:0] b,
  input  logic                cin,
`ifdef MULTIWORD_SUB_EN
  input  logic                sub,
`endif
  output logic                out_valid,
  input  logic                out_ready,
  output logic [16*WORDS-1:0] sum,
  output logic                cout
);

  localparam int IW = $clog2(WORDS) + 1;
  localparam int SW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                 state, state_nxt;
  logic [WORDS-1:0][15:0] a_reg, b_reg, sum_reg;
  logic [IW-1:0]          idx;
  logic [SW-1:0]          sel;
  logic                   carry;
  logic [16*WORDS-1:0]    b_eff;
  logic                   cin_eff;
  logic [16:0]            res;

`ifdef MULTIWORD_SUB_EN
  // Subtraction is A + ~B + 1, so sub forces slice-0 carry to 1 and ignores cin.
  assign b_eff   = sub ? ~b : b;
  assign cin_eff = sub ? 1'b1 : cin;
`else
  assign b_eff   = b;
  assign cin_eff = cin;
`endif

  assign sel       = idx[SW-1:0];
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign sum       = sum_reg;

  kpg_adder16 u_add (
    .a   (a_reg[sel]),
    .b   (b_reg[sel]),
    .cin (carry),
    .res (res)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    // NOTE: sequential state uses non-blocking assignment so all flops update together.
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)     state_nxt = RUN;
      RUN:     if (idx == LAST)  state_nxt = DONE;
      DONE:    if (out_ready)    state_nxt = IDLE;
      default:                   state_nxt = IDLE;
    endcase
  end

  // Datapath. Capture operands at accept, then write one sum slice per RUN cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: operand/sum registers are reset too, so an aborted run leaves no stale slices visible.
      a_reg   <= '0;
      b_reg   <= '0;
      sum_reg <= '0;
      cout    <= 1'b0;
      idx     <= '0;
      carry   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg <= a;
            b_reg <= b_eff;
            carry <= cin_eff;
            idx   <= '0;
          end
        end
        RUN: begin
          sum_reg[sel] <= res[15:0];
          carry        <= res[16];
          if (idx == LAST) cout <= res[16];
          else             idx  <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multiword_seq_adder.sv
// Directed testbench for multiword_seq_adder with WORDS=4.
// Inputs are driven 1 time unit after each rising edge, and outputs are
// sampled at that same point.
`timescale 1ns/1ps
module tb_multiword_seq_adder;

  localparam int WORDS = 4;
  localparam int W     = 16 * WORDS;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a, b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
`ifdef MULTIWORD_SUB_EN
  logic         sub;
`endif

  int n_vec = 0;
  int n_err = 0;

  multiword_seq_adder #(.WORDS(WORDS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef MULTIWORD_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one operand set for one edge, then scramble the inputs.
  // The DUT must have latched them at accept.
  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc,
                      input logic ts);
    in_valid = 1'b1;
    a = ta;
    b = tb_v;
    cin = tc;
`ifdef MULTIWORD_SUB_EN
    sub = ts;
`endif
    tick();
    in_valid = 1'b0;
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    cin = 1'b0;
`ifdef MULTIWORD_SUB_EN
    sub = 1'b0;
`endif
  endtask

  // Count edges until out_valid. A timeout shows up as a latency miscompare.
  task automatic wait_valid(output int lat);
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!out_valid && lat < 20);
  endtask

  // Full operation: send, check latency and result, then drain.
  task automatic op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                    input logic tc, input logic ts, input logic [W-1:0] es, input logic ec);
    int lat;
    send(ta, tb_v, tc, ts);
    check({tag, ".busy"}, in_ready, 1'b0);
    wait_valid(lat);
    check({tag, ".lat"}, lat, WORDS);
    check({tag, ".sum"}, sum, es);
    check({tag, ".cout"}, cout, ec);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, ".drain"}, {in_ready, out_valid}, 2'b10);
  endtask

  initial begin
    int lat;
    logic [W-1:0] held_sum;
    logic         held_cout;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0;
`ifdef MULTIWORD_SUB_EN
    sub = 1'b0;
`endif
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    check("rst.in_ready", in_ready, 1'b1);
    check("rst.out_valid", out_valid, 1'b0);
    check("rst.sum", sum, 64'h0);
    check("rst.cout", cout, 1'b0);

    op("basic", 64'h56, 64'h5D, 1'b0, 1'b0, 64'hB3, 1'b0);
    op("ripple", 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0, 64'h0, 1'b1);
    op("alt", 64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001, 1'b0, 1'b0,
       64'h0001_0000_0001_0000, 1'b0);
    op("comp", 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b0, 1'b0,
       64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    op("msb", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0001, 1'b1, 1'b0,
       64'h0000_0000_0000_0002, 1'b1);

    // Backpressure: hold the result while a second operand set waits.
    send(64'h1111, 64'h2222, 1'b0, 1'b0);
    wait_valid(lat);
    check("bp.lat", lat, WORDS);
    held_sum  = sum;
    held_cout = cout;
    check("bp.sum", held_sum, 64'h3333);
    in_valid = 1'b1; a = 64'h1; b = 64'h1; cin = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp.hold", {out_valid, in_ready, cout, sum}, {1'b1, 1'b0, held_cout, held_sum});
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp.release", {in_ready, out_valid}, 2'b10);
    tick();                       // pending operand accepted on this edge
    in_valid = 1'b0;
    check("bp.accepted", in_ready, 1'b0);
    wait_valid(lat);
    check("bp2.lat", lat, WORDS);
    check("bp2.sum", sum, 64'h2);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Async reset at idx=2. The carry register holds 1 at that point.
    send(64'h0000_0000_FFFF_0005, 64'h0000_0000_0001_0003, 1'b0, 1'b0);
    tick();
    tick();
    check("ar.partial", sum, 64'h8);
    #2 rst_n = 1'b0;
    #1;
    check("ar.clear", {in_ready, out_valid, cout, sum}, {1'b1, 1'b0, 1'b0, 64'h0});
    tick();
    rst_n = 1'b1;
    tick();
    op("ar.next", 64'h1234, 64'h0001, 1'b0, 1'b0, 64'h1235, 1'b0);

`ifdef MULTIWORD_SUB_EN
    op("sub.neg", 64'h5, 64'h7, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
    op("sub.pos", 64'h7, 64'h5, 1'b0, 1'b1, 64'h2, 1'b1);
    op("sub.off", 64'h7, 64'h5, 1'b0, 1'b0, 64'hC, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/multiword_seq_adder.md
Name: multiword_seq_adder

Overview:
- Sequential wide-operand adder that sits in front of and behind the team's combinational 16-bit recursive-doubling (kpg) adder.
- Accepts two WORDS×16-bit operands plus a carry-in over a valid/ready handshake.
- Feeds one 16-bit slice per cycle, LSB slice first, into a single instance of the 16-bit adder. Bit 16 of the adder's 17-bit result is chained as the next slice's cin.
- Assembles the full sum and carry-out and presents them on a valid/ready output handshake.

Parameters:
- WORDS, 4, number of 16-bit slices per operand; legal range 1..16; operand width W = 16*WORDS.

Ports:
- clk  input  1  single clock, all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand set offered
- in_ready  output  1  block can accept operands
- a  input  W  operand A
- b  input  W  operand B
- cin  input  1  carry into slice 0
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- sum  output  W  A + B + cin, modulo 2^W
- cout  output  1  carry out of slice WORDS-1

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, in_ready=1, out_valid=0, sum=0, cout=0, slice index=0, carry reg=0.
- Reset mid-operation aborts the in-flight addition and discards it. No partial result is ever presented.
- FSM has three states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready at an edge: latch a, b, cin into operand registers, set idx=0, carry reg=cin, go to RUN.
- RUN:
  - in_ready=0.
  - Adder inputs are a_reg[16*idx+:16], b_reg[16*idx+:16], carry reg.
  - Each edge: sum[16*idx+:16] <= adder[15:0], carry reg <= adder[16], idx <= idx+1.
  - When idx==WORDS-1: cout <= adder[16], out_valid <= 1, go to DONE.
- DONE:
  - out_valid=1; sum and cout are held stable.
  - On out_ready high at an edge: out_valid <= 0, go to IDLE. in_ready rises in the same cycle.
- Latency: out_valid is asserted exactly WORDS cycles after the accept edge. Throughput is one operation per WORDS+2 cycles minimum.
- WORDS=1: one RUN cycle, then DONE.
- Input changes on a and b while not in IDLE are ignored, because operands are registered at accept.
- in_valid while busy is not accepted; the producer must hold it.
- out_ready while out_valid=0 has no effect.
- sum holds its last result in IDLE and is overwritten slice by slice during the next RUN. Consumers sample it only when out_valid=1.
- idx is an unsigned counter of width clog2(WORDS)+1. It never wraps past WORDS-1 within an operation.
- Adder interface: 16-bit a, 16-bit b, 1-bit cin in; 17-bit result out {carry, sum}. The path from registers through the adder to the registers is purely combinational.

Optional Feature:
- Macro: MULTIWORD_SUB_EN.
- Defined:
  - Extra input port sub (1 bit), sampled at accept.
  - When sub=1, b_reg <= ~b and the slice-0 carry <= 1, so the result is A − B modulo 2^W. cin is ignored.
  - cout=1 means no borrow, i.e. A ≥ B unsigned.
  - sub=0 behaves exactly as the base add.
- Not defined: no sub port; add only, identical to the base behaviour above.

Test Plan (WORDS=4):
- Reset: hold rst_n low for 3 cycles, then release -> in_ready=1, out_valid=0, sum=0, cout=0.
- Basic add: a=0x0000_0000_0000_0056, b=0x0000_0000_0000_005D, cin=0 -> out_valid asserted 4 cycles after accept, sum=0x...00B3, cout=0.
- Full carry ripple across slices: a=0xFFFF_FFFF_FFFF_FFFF, b=0, cin=1 -> sum=0, cout=1. Carry chain exercises every slice boundary.
- Backpressure and busy: hold out_ready=0 for 5 cycles -> out_valid stays 1, sum/cout stable, in_ready=0. A second in_valid during this time is not accepted until the cycle after out_ready=1.
- Async reset mid-RUN: pull rst_n low at idx=2 -> outputs clear immediately without waiting for a clock edge. The next operation 0x1234 + 0x0001 yields 0x1235 with no stale carry.
- With MULTIWORD_SUB_EN: a=5, b=7, sub=1 -> sum=0xFFFF_FFFF_FFFF_FFFE, cout=0. Then a=7, b=5, sub=1 -> sum=2, cout=1.
